// File: rtl/jtag_tap_ir_if.sv
// Pin-side and parallel USER port bundle for jtag_tap_ir.
// master: the JTAG host / system side; slave: the TAP itself.
interface jtag_tap_ir_if #(
    parameter int USER_WIDTH = 8
);
    logic                  tms;
    logic                  tdi;
    logic                  tdo;
    logic                  tdo_en;
    logic [USER_WIDTH-1:0] user_capture_data;
    logic [USER_WIDTH-1:0] user_update_data;
    logic                  user_update_strobe;

    modport master (
        output tms, tdi, user_capture_data,
        input  tdo, tdo_en, user_update_data, user_update_strobe
    );

    modport slave (
        input  tms, tdi, user_capture_data,
        output tdo, tdo_en, user_update_data, user_update_strobe
    );
endinterface

// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, USER and optional IDCODE data registers.
// Define TAP_IDCODE_EN to build the 32-bit IDCODE register; otherwise IDCODE_OP selects BYPASS.
module jtag_tap_ir #(
    parameter int          IR_WIDTH     = 4,
    parameter int          USER_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VALUE = 32'h0BA0_0477,
    parameter int          IDCODE_OP    = 1,
    parameter int          USER_OP      = 2
) (
    input  logic                tclk,
    input  logic                trst,
    output logic [3:0]          state,
    output logic [IR_WIDTH-1:0] ir_out,
    jtag_tap_ir_if.slave        jtag
);

    typedef enum logic [3:0] {
        TLR    = 4'h0, RTI    = 4'h1,
        SEL_DR = 4'h2, CAP_DR = 4'h3, SH_DR  = 4'h4, EX1_DR = 4'h5,
        PA_DR  = 4'h6, EX2_DR = 4'h7, UPD_DR = 4'h8,
        SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB, EX1_IR = 4'hC,
        PA_IR  = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] BYPASS_CODE = {IR_WIDTH{1'b1}};
    localparam logic [IR_WIDTH-1:0] USER_CODE   = IR_WIDTH'(USER_OP);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(IDCODE_OP);
    localparam logic [IR_WIDTH-1:0] RESET_IR    = IDCODE_CODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_IR    = BYPASS_CODE;
`endif

    generate
        if (IR_WIDTH < 2 || USER_WIDTH < 1 || IDCODE_VALUE[0] != 1'b1 || IDCODE_OP == USER_OP) begin : g_bad_params
            $error("jtag_tap_ir: illegal parameter combination");
        end
    endgenerate

    tap_state_t            cur_state, next_state;
    logic [IR_WIDTH-1:0]   ir_sr;
    logic                  bypass_sr;
    logic [USER_WIDTH-1:0] user_sr;
    logic                  sel_user;
    logic                  dr_lsb;
    logic                  tdo_q, tdo_en_q;
    logic [USER_WIDTH-1:0] update_q;
    logic                  strobe_q;

    // The all-ones opcode is always BYPASS, even if USER_OP collides with it.
    assign sel_user = (ir_out == USER_CODE) && (ir_out != BYPASS_CODE);

`ifdef TAP_IDCODE_EN
    logic [31:0] idcode_sr;
    logic        sel_idcode;
    assign sel_idcode = (ir_out == IDCODE_CODE) && (ir_out != BYPASS_CODE) && !sel_user;

    always_ff @(posedge tclk or negedge trst) begin
        if (!trst)
            idcode_sr <= '0;
        else if (sel_idcode && cur_state == CAP_DR)
            idcode_sr <= IDCODE_VALUE;
        else if (sel_idcode && cur_state == SH_DR)
            idcode_sr <= {jtag.tdi, idcode_sr[31:1]};
    end
`endif

    always_ff @(posedge tclk or negedge trst) begin
        if (!trst)
            cur_state <= TLR;
        else
            cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            TLR:    next_state = jtag.tms ? TLR    : RTI;
            RTI:    next_state = jtag.tms ? SEL_DR : RTI;
            SEL_DR: next_state = jtag.tms ? SEL_IR : CAP_DR;
            CAP_DR: next_state = jtag.tms ? EX1_DR : SH_DR;
            SH_DR:  next_state = jtag.tms ? EX1_DR : SH_DR;
            EX1_DR: next_state = jtag.tms ? UPD_DR : PA_DR;
            PA_DR:  next_state = jtag.tms ? EX2_DR : PA_DR;
            EX2_DR: next_state = jtag.tms ? UPD_DR : SH_DR;
            UPD_DR: next_state = jtag.tms ? SEL_DR : RTI;
            SEL_IR: next_state = jtag.tms ? TLR    : CAP_IR;
            CAP_IR: next_state = jtag.tms ? EX1_IR : SH_IR;
            SH_IR:  next_state = jtag.tms ? EX1_IR : SH_IR;
            EX1_IR: next_state = jtag.tms ? UPD_IR : PA_IR;
            PA_IR:  next_state = jtag.tms ? EX2_IR : PA_IR;
            EX2_IR: next_state = jtag.tms ? UPD_IR : SH_IR;
            UPD_IR: next_state = jtag.tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    assign state = cur_state;

    always_ff @(posedge tclk or negedge trst) begin
        if (!trst)
            ir_sr <= '0;
        else if (cur_state == CAP_IR)
            ir_sr <= IR_CAPTURE;
        else if (cur_state == SH_IR)
            ir_sr <= {jtag.tdi, ir_sr[IR_WIDTH-1:1]};
    end

    // Reloading on the edge that enters Test-Logic-Reset means the default
    // instruction is already active when five TMS=1 clocks land in TLR.
    always_ff @(posedge tclk or negedge trst) begin
        if (!trst)
            ir_out <= RESET_IR;
        else if (cur_state == TLR || next_state == TLR)
            ir_out <= RESET_IR;
        else if (cur_state == UPD_IR)
            ir_out <= ir_sr;
    end

    always_ff @(posedge tclk or negedge trst) begin
        if (!trst) begin
            bypass_sr <= 1'b0;
            user_sr   <= '0;
        end else if (cur_state == CAP_DR) begin
            bypass_sr <= 1'b0;
            if (sel_user)
                user_sr <= jtag.user_capture_data;
        end else if (cur_state == SH_DR) begin
            bypass_sr <= jtag.tdi;
            if (sel_user)
                user_sr <= USER_WIDTH'({jtag.tdi, user_sr} >> 1);
        end
    end

    always_comb begin
        dr_lsb = bypass_sr;
        if (sel_user)
            dr_lsb = user_sr[0];
`ifdef TAP_IDCODE_EN
        if (sel_idcode)
            dr_lsb = idcode_sr[0];
`endif
    end

    // TDO launches on the falling edge so the host can sample it on the next rising edge.
    always_ff @(negedge tclk or negedge trst) begin
        if (!trst) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (cur_state == SH_IR) begin
            tdo_q    <= ir_sr[0];
            tdo_en_q <= 1'b1;
        end else if (cur_state == SH_DR) begin
            tdo_q    <= dr_lsb;
            tdo_en_q <= 1'b1;
        end else begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end
    end

    always_ff @(posedge tclk or negedge trst) begin
        if (!trst) begin
            update_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (cur_state == UPD_DR && sel_user) begin
                update_q <= user_sr;
                strobe_q <= 1'b1;
            end
        end
    end

    assign jtag.tdo                = tdo_q;
    assign jtag.tdo_en             = tdo_en_q;
    assign jtag.user_update_data   = update_q;
    assign jtag.user_update_strobe = strobe_q;

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Scoreboard bench for jtag_tap_ir: expected TDO bits are queued as scans are driven
// and compared against the bits the TAP shifts out. Follows TAP_IDCODE_EN like the RTL.
module tb_jtag_tap_ir;

    localparam int          IRW    = 4;
    localparam int          UW     = 8;
    localparam logic [31:0] IDC    = 32'h0BA0_0477;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0]  RST_IR = 4'h1;
    localparam bit          HAS_ID = 1'b1;
`else
    localparam logic [3:0]  RST_IR = 4'hF;
    localparam bit          HAS_ID = 1'b0;
`endif

    logic           tclk;
    logic           trst;
    logic [3:0]     state;
    logic [IRW-1:0] ir_out;

    jtag_tap_ir_if #(.USER_WIDTH(UW)) bus ();

    jtag_tap_ir #(
        .IR_WIDTH(IRW), .USER_WIDTH(UW), .IDCODE_VALUE(IDC), .IDCODE_OP(1), .USER_OP(2)
    ) dut (
        .tclk(tclk), .trst(trst), .state(state), .ir_out(ir_out), .jtag(bus)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic exp_q[$];
    logic obs_q[$];
    logic en_q[$];
    logic post_en;

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One TCK: inputs change just after the falling edge; DUT sampled just after the next one.
    task automatic step(input logic t, input logic d);
        bus.tms = t;
        bus.tdi = d;
        @(posedge tclk);
        @(negedge tclk);
        #1;
    endtask

    // Entered in Shift-xR with bit 0 already on TDO; leaves in Exit1-xR.
    task automatic shift_bits(input logic [63:0] din, input int n);
        for (int i = 0; i < n; i++) begin
            obs_q.push_back(bus.tdo);
            en_q.push_back(bus.tdo_en);
            step(i == n - 1, din[i]);
        end
        post_en = bus.tdo_en;
    endtask

    task automatic load_ir(input logic [3:0] code);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back(i == 0);
        shift_bits({60'd0, code}, 4);
        step(1, 0); step(0, 0);
        while (exp_q.size() > 0) begin
            logic e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL ir_capture_bit: got %b want %b", o, e);
            end
        end
        en_q.delete();
    endtask

    task automatic test_reset;
        trst = 1'b0;
        #2;
        tests_run++;
        if (state !== 4'h0 || ir_out !== RST_IR || bus.tdo !== 1'b0 || bus.tdo_en !== 1'b0 ||
            bus.user_update_data !== 8'h00 || bus.user_update_strobe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got state=%h ir=%h tdo=%b en=%b upd=%h stb=%b want 0 %h 0 0 00 0",
                     state, ir_out, bus.tdo, bus.tdo_en, bus.user_update_data, bus.user_update_strobe, RST_IR);
        end
        trst = 1'b1;
    endtask

    task automatic test_idcode;
        logic [31:0] din;
        logic        pre_en;
        din = 32'h1234_5678;
        step(0, 0); step(1, 0); step(0, 0);
        pre_en = bus.tdo_en;
        step(0, 0);
        for (int i = 0; i < 32; i++)
            exp_q.push_back(HAS_ID ? IDC[i] : (i == 0 ? 1'b0 : din[i-1]));
        shift_bits({32'd0, din}, 32);
        tests_run++;
        if (obs_q.size() != 32) begin
            tests_failed++;
            $display("[TB] FAIL idcode_count: got %0d want 32", obs_q.size());
        end
        for (int i = 0; i < 32 && obs_q.size() > 0; i++) begin
            logic e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL idcode_bit%0d: got %b want %b", i, o, e);
            end
        end
        exp_q.delete();
        tests_run++;
        if (en_q.size() != 32 || (32'(en_q.sum() with (int'(item)))) != 32 || post_en !== 1'b0 || pre_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idcode_tdo_en: got pre=%b high=%0d post=%b want 0 32 0",
                     pre_en, en_q.sum() with (int'(item)), post_en);
        end
        en_q.delete();
        step(1, 0); step(0, 0);
    endtask

    task automatic test_ir_capture;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        shift_bits(64'hF, 4);
        for (int i = 0; i < 4; i++) begin
            logic e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL ir_readback_bit%0d: got %b want %b", i, o, e);
            end
        end
        en_q.delete();
        step(1, 0);
        tests_run++;
        if (ir_out !== RST_IR) begin
            tests_failed++;
            $display("[TB] FAIL ir_hold_in_update: got %h want %h", ir_out, RST_IR);
        end
        step(0, 0);
        tests_run++;
        if (ir_out !== 4'hF || state !== 4'h1) begin
            tests_failed++;
            $display("[TB] FAIL ir_update: got ir=%h state=%h want f 1", ir_out, state);
        end
    endtask

    task automatic test_bypass;
        logic [7:0] din;
        din = 8'hA5;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 8; i++) exp_q.push_back(i == 0 ? 1'b0 : din[i-1]);
        shift_bits({56'd0, din}, 8);
        for (int i = 0; i < 8; i++) begin
            logic e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL bypass_bit%0d: got %b want %b", i, o, e);
            end
        end
        en_q.delete();
        step(1, 0); step(0, 0);
        tests_run++;
        if (bus.user_update_strobe !== 1'b0 || bus.user_update_data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL bypass_no_strobe: got stb=%b upd=%h want 0 00",
                     bus.user_update_strobe, bus.user_update_data);
        end
    endtask

    task automatic test_user;
        load_ir(4'h2);
        tests_run++;
        if (ir_out !== 4'h2) begin
            tests_failed++;
            $display("[TB] FAIL user_ir_load: got %h want 2", ir_out);
        end
        bus.user_capture_data = 8'h3C;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 8; i++) exp_q.push_back(bus.user_capture_data[i]);
        shift_bits(64'hC3, 8);
        for (int i = 0; i < 8; i++) begin
            logic e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL user_capture_bit%0d: got %b want %b", i, o, e);
            end
        end
        en_q.delete();
        tests_run++;
        if (ir_out !== 4'h2) begin
            tests_failed++;
            $display("[TB] FAIL user_ir_stable: got %h want 2", ir_out);
        end
        step(1, 0);
        tests_run++;
        if (bus.user_update_strobe !== 1'b0 || bus.user_update_data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL user_pre_update: got stb=%b upd=%h want 0 00",
                     bus.user_update_strobe, bus.user_update_data);
        end
        step(0, 0);
        tests_run++;
        if (bus.user_update_data !== 8'hC3 || bus.user_update_strobe !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL user_update: got upd=%h stb=%b want c3 1",
                     bus.user_update_data, bus.user_update_strobe);
        end
        step(0, 0);
        tests_run++;
        if (bus.user_update_strobe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL user_strobe_width: got %b want 0", bus.user_update_strobe);
        end
    endtask

    task automatic test_pause;
        logic [7:0] din;
        din = 8'h96;
        bus.user_capture_data = 8'h5A;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 8; i++) exp_q.push_back(bus.user_capture_data[i]);
        shift_bits({60'd0, din[3:0]}, 4);
        step(0, 0);
        tests_run++;
        if (state !== 4'h6) begin
            tests_failed++;
            $display("[TB] FAIL pause_state: got %h want 6", state);
        end
        bus.user_capture_data = 8'hFF;
        step(0, 0); step(1, 0); step(0, 0);
        shift_bits({60'd0, din[7:4]}, 4);
        for (int i = 0; i < 8; i++) begin
            logic e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL pause_bit%0d: got %b want %b", i, o, e);
            end
        end
        en_q.delete();
        step(1, 0); step(0, 0);
        tests_run++;
        if (bus.user_update_data !== din || bus.user_update_strobe !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pause_update: got upd=%h stb=%b want %h 1",
                     bus.user_update_data, bus.user_update_strobe, din);
        end
    endtask

    task automatic test_reset_mid_shift;
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1); step(0, 0);
        tests_run++;
        if (state !== 4'h4 || bus.tdo_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midshift_pre: got state=%h en=%b want 4 1", state, bus.tdo_en);
        end
        trst = 1'b0;
        #2;
        tests_run++;
        if (state !== 4'h0 || ir_out !== RST_IR || bus.tdo_en !== 1'b0 ||
            bus.user_update_data !== 8'h00 || bus.user_update_strobe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midshift_reset: got state=%h ir=%h en=%b upd=%h stb=%b want 0 %h 0 00 0",
                     state, ir_out, bus.tdo_en, bus.user_update_data, bus.user_update_strobe, RST_IR);
        end
        trst = 1'b1;
        step(1, 0);
        tests_run++;
        if (state !== 4'h0 || bus.user_update_strobe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midshift_after: got state=%h stb=%b want 0 0", state, bus.user_update_strobe);
        end
        step(0, 0);
    endtask

    task automatic test_tms_reset;
        load_ir(4'h2);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(1, 0); step(0, 0);
        tests_run++;
        if (state !== 4'hD) begin
            tests_failed++;
            $display("[TB] FAIL tms_pause_ir: got %h want d", state);
        end
        step(1, 0); step(1, 0); step(1, 0);
        tests_run++;
        if (ir_out !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL tms_update_ir: got %h want 0", ir_out);
        end
        step(1, 0); step(1, 0);
        tests_run++;
        if (state !== 4'h0 || ir_out !== RST_IR) begin
            tests_failed++;
            $display("[TB] FAIL tms_reset: got state=%h ir=%h want 0 %h", state, ir_out, RST_IR);
        end
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        exp_q.push_back(HAS_ID ? IDC[0] : 1'b0);
        exp_q.push_back(HAS_ID ? IDC[1] : 1'b1);
        shift_bits(64'h1, 2);
        for (int i = 0; i < 2; i++) begin
            logic e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL tms_dr_bit%0d: got %b want %b", i, o, e);
            end
        end
        en_q.delete();
        step(1, 0); step(0, 0);
    endtask

    initial begin
        trst                  = 1'b0;
        bus.tms               = 1'b1;
        bus.tdi               = 1'b0;
        bus.user_capture_data = 8'h00;
        @(negedge tclk);
        #1;
        test_reset();
        test_idcode();
        test_ir_capture();
        test_bypass();
        test_user();
        test_pause();
        test_reset_mid_shift();
        test_tms_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
